// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package serial_pattern_pkg;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int DIV_W   = 8;
    localparam int RPT_W   = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

endpackage

// File: rtl/serial_pattern_tx_bit_timer.sv
// Loadable bit-period down-counter: bit_start marks a bit's first clock,
// bit_end marks its last (each bit lasts period+1 clocks).
module bit_timer #(
    parameter int DIV_W = serial_pattern_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    output logic             bit_start,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt;
    logic             first;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (load) begin
            cnt   <= period;
            first <= 1'b1;
        end else begin
            first <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign bit_start = first;
    assign bit_end   = (cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern generator, MSB of the active field first, with repeat passes.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit to every pass.
module serial_pattern_tx #(
    parameter int MAX_LEN = serial_pattern_pkg::MAX_LEN,
    parameter int LEN_W   = serial_pattern_pkg::LEN_W,
    parameter int DIV_W   = serial_pattern_pkg::DIV_W,
    parameter int RPT_W   = serial_pattern_pkg::RPT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [DIV_W-1:0]   div,
    input  logic [RPT_W-1:0]   rpt,
    input  logic               idle_level,
    output logic               ready,
    output logic               x_out,
    output logic               x_valid,
    output logic [LEN_W-1:0]   bit_idx,
    output logic               done
);

    import serial_pattern_pkg::*;

    localparam int IDX_W = $clog2(MAX_LEN);

    state_t state, next_state;

    logic [MAX_LEN-1:0] pat_l;
    logic [LEN_W-1:0]   len_l;
    logic [DIV_W-1:0]   div_l;
    logic [RPT_W-1:0]   rpt_l;
    logic [RPT_W-1:0]   pass_cnt;
    logic [LEN_W-1:0]   eff_len;
    logic [IDX_W-1:0]   acc_idx, nxt_idx, rel_idx;
    logic [DIV_W-1:0]   period;
    logic               bit_start, bit_end, last_bit, more_passes, timer_load;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic [MAX_LEN-1:0] field_mask;
    logic               par_l;
`endif

    always_comb begin
        eff_len = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        acc_idx = IDX_W'(eff_len - 1'b1);
        nxt_idx = IDX_W'(bit_idx - 1'b1);
        rel_idx = IDX_W'(len_l - 1'b1);
    end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    always_comb field_mask = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - eff_len);
`endif

    assign last_bit    = bit_end && (bit_idx == '0);
    assign more_passes = (pass_cnt < rpt_l);
    // The accept edge still sees the raw div input; later bits use the latched copy.
    assign period      = (state == IDLE) ? div : div_l;
    assign timer_load  = ((next_state == SHIFT) || (next_state == PAR)) &&
                         ((state == IDLE) || bit_end);

    bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .period    (period),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = (eff_len == '0) ? DONE : SHIFT;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            SHIFT: if (last_bit) next_state = PAR;
            PAR:   if (bit_end) next_state = more_passes ? SHIFT : DONE;
`else
            SHIFT: if (last_bit) next_state = more_passes ? SHIFT : DONE;
`endif
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == IDLE);
        done    = (state == DONE);
        x_valid = bit_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_out    <= 1'b0;
            bit_idx  <= '0;
            pass_cnt <= '0;
            pat_l    <= '0;
            len_l    <= '0;
            div_l    <= '0;
            rpt_l    <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_l    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    x_out <= idle_level;
                    if (start) begin
                        pat_l    <= pattern;
                        len_l    <= eff_len;
                        div_l    <= div;
                        rpt_l    <= rpt;
                        pass_cnt <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        par_l    <= ^(pattern & field_mask);
`endif
                        if (eff_len != '0) begin
                            bit_idx <= eff_len - 1'b1;
                            x_out   <= pattern[acc_idx];
                        end else begin
                            bit_idx <= '0;
                        end
                    end
                end
                SHIFT: if (bit_end) begin
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        x_out   <= pat_l[nxt_idx];
                    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    else x_out <= par_l;
`else
                    else if (more_passes) begin
                        pass_cnt <= pass_cnt + 1'b1;
                        bit_idx  <= len_l - 1'b1;
                        x_out    <= pat_l[rel_idx];
                    end else begin
                        x_out <= idle_level;
                    end
`endif
                end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                PAR: if (bit_end) begin
                    if (more_passes) begin
                        pass_cnt <= pass_cnt + 1'b1;
                        bit_idx  <= len_l - 1'b1;
                        x_out    <= pat_l[rel_idx];
                    end else begin
                        x_out <= idle_level;
                    end
                end
`endif
                default: x_out <= idle_level;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: a per-cycle expectation queue built
// from the transfer rules, plus literal latency and bit-sequence checks.
module tb_serial_pattern_tx;

    localparam int ML = 16;
    localparam int LW = 5;
    localparam int DW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset, start, idle_level;
    logic [ML-1:0] pattern;
    logic [LW-1:0] len;
    logic [DW-1:0] div;
    logic [RW-1:0] rpt;
    logic          ready, x_out, x_valid, done;
    logic [LW-1:0] bit_idx;

    typedef struct packed {
        logic          x;
        logic          v;
        logic [LW-1:0] idx;
        logic          dn;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    int   acc_cyc  = 0;
    logic armed    = 1'b0;

    serial_pattern_tx #(.MAX_LEN(ML), .LEN_W(LW), .DIV_W(DW), .RPT_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .div        (div),
        .rpt        (rpt),
        .idle_level (idle_level),
        .ready      (ready),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .bit_idx    (bit_idx),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line content for every cycle of one transfer, from the rules alone.
    task automatic build(input logic [15:0] pat, input int l, input int d, input int r, input logic il);
        int eff;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        logic [31:0] m;
        logic        par;
`endif
        eff = (l > ML) ? ML : l;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        m   = (32'd1 << eff) - 32'd1;
        par = ^({16'd0, pat} & m);
`endif
        if (eff > 0) begin
            for (int p = 0; p <= r; p++) begin
                for (int b = eff - 1; b >= 0; b--)
                    for (int c = 0; c <= d; c++)
                        q.push_back('{x: pat[b], v: (c == 0), idx: LW'(b), dn: 1'b0});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                for (int c = 0; c <= d; c++)
                    q.push_back('{x: par, v: (c == 0), idx: '0, dn: 1'b0});
`endif
            end
        end
        q.push_back('{x: il, v: 1'b0, idx: '0, dn: 1'b1});
    endtask

    task automatic do_start(input logic [15:0] pat, input int l, input int d, input int r);
        @(negedge clk);
        check("ready_before_start", {31'd0, ready}, 32'd1);
        pattern = pat; len = LW'(l); div = DW'(d); rpt = RW'(r); start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        acc_cyc = cyc_cnt;
        build(pat, l, d, r, idle_level);
    endtask

    task automatic wait_done(input int lat_plain, input int lat_par);
        int lat;
        int seen;
        lat = -1;
        seen = 0;
        for (int i = 0; i < 700 && seen == 0; i++) begin
            @(negedge clk);
            if (done) begin
                lat  = cyc_cnt - acc_cyc + 1;
                seen = 1;
            end
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        check("done_latency", lat, lat_par);
`else
        check("done_latency", lat, lat_plain);
`endif
        @(negedge clk);
        check("ready_after_done", {31'd0, ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && armed) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                check("x_out", {31'd0, x_out}, {31'd0, e.x});
                check("x_valid", {31'd0, x_valid}, {31'd0, e.v});
                check("done", {31'd0, done}, {31'd0, e.dn});
                check("ready_busy", {31'd0, ready}, 32'd0);
                if (!e.dn)
                    check("bit_idx", {27'd0, bit_idx}, {27'd0, e.idx});
            end else begin
                check("ready_idle", {31'd0, ready}, 32'd1);
                check("done_idle", {31'd0, done}, 32'd0);
                check("x_valid_idle", {31'd0, x_valid}, 32'd0);
            end
        end
    end

    initial begin
        logic [15:0] bits;
        reset = 1'b1; start = 1'b0; pattern = '0; len = '0; div = '0; rpt = '0; idle_level = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_x_out", {31'd0, x_out}, 32'd0);
        check("rst_x_valid", {31'd0, x_valid}, 32'd0);
        check("rst_bit_idx", {27'd0, bit_idx}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        armed = 1'b1;
        repeat (2) @(negedge clk);

        do_start(16'b100, 3, 0, 0);
        wait_done(4, 5);

        do_start(16'b010, 3, 2, 1);
        wait_done(19, 25);

        @(negedge clk);
        idle_level = 1'b1;
        do_start(16'hFFFF, 0, 0, 0);
        wait_done(1, 1);
        check("len0_line_idle", {31'd0, x_out}, 32'd1);

        do_start(16'hA5A5, 20, 0, 0);
        bits = '0;
        for (int i = 0; i < 16; i++) bits = {bits[14:0], q[i].x};
        check("clamp_model_bits", {16'd0, bits}, 32'b1010010110100101);
        wait_done(17, 18);

        do_start(16'h0001, 1, 255, 0);
        wait_done(257, 513);

        // Restart and input changes mid-transfer must not disturb the bits in flight.
        do_start(16'h00C3, 8, 3, 0);
        repeat (5) @(negedge clk);
        pattern = 16'hFFFF; len = 5'd2; div = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; pattern = 16'h0000;
        wait_done(33, 37);

        do_start(16'h00F0, 8, 3, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_x_valid", {31'd0, x_valid}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_x_out", {31'd0, x_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_line_idle", {31'd0, x_out}, 32'd1);
        repeat (40) @(negedge clk);

        do_start(16'b100, 3, 0, 0);
        wait_done(4, 5);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
        do_start(16'b110, 3, 0, 0);
        bits = '0;
        for (int i = 0; i < 4; i++) bits = {bits[14:0], q[i].x};
        check("par_model_110", {16'd0, bits}, 32'b1100);
        wait_done(4, 5);

        do_start(16'b100, 3, 0, 0);
        bits = '0;
        for (int i = 0; i < 4; i++) bits = {bits[14:0], q[i].x};
        check("par_model_100", {16'd0, bits}, 32'b1001);
        wait_done(4, 5);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
